// File: rtl/alarm_trigger_pkg.sv
// alarm_pkg: shared constants for the alarm trigger (states, time-word layout, defaults)
package alarm_pkg;
    typedef logic [51:0] time_word_t;
    localparam int DEF_RING_SEC   = 60;
    localparam int DEF_SNOOZE_SEC = 300;
    localparam int DEF_MAX_SNOOZE = 3;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_RING   = 2'd2;
    localparam logic [1:0] ST_SNOOZE = 2'd3;
    localparam int SEC_LSB   = 0;
    localparam int MIN_LSB   = 8;
    localparam int HOUR_LSB  = 16;
    localparam int DAY_LSB   = 24;
    localparam int MONTH_LSB = 32;
    localparam int YEAR_LSB  = 40;
    localparam int FIELD_W   = 8;
    localparam int YEAR_W    = 12;
    localparam time_word_t NO_ALARM = 52'd0;
    localparam logic [3:0] SW_SNOOZE = 4'b0001;
endpackage

// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: time words and buttons in, buzzer and status flags out
//   bin_alarm/bin_now : packed {year12,month8,day8,hour8,minute8,second8}
//   sw_in             : one-clk button pulses, 4'b0001 = snooze, other nonzero = dismiss
//   buzz/ringing/snoozing/snooze_left : registered status back to the pin and LCD
interface alarm_trigger_if;
    import alarm_pkg::*;
    time_word_t bin_alarm;
    time_word_t bin_now;
    logic [3:0] sw_in;
    logic       buzz;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_left;
    modport master (output bin_alarm, bin_now, sw_in, input buzz, ringing, snoozing, snooze_left);
    modport slave  (input bin_alarm, bin_now, sw_in, output buzz, ringing, snoozing, snooze_left);
endinterface

// File: rtl/alarm_trigger_sec_tick.sv
// sec_tick: synchronises the 1 Hz square wave and flags its rising edge
//   clk, rst (async active-low), clk1sec in; tick = one-clk pulse, lvl = synchronised level
module sec_tick (
    input  logic clk,
    input  logic rst,
    input  logic clk1sec,
    output logic tick,
    output logic lvl
);
    logic [2:0] sh;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sh <= '0;
        else      sh <= {sh[1:0], clk1sec};
    assign lvl  = sh[1];
    assign tick = sh[1] & ~sh[2];
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: fires when the alarm time matches now, beeps at 1 Hz, handles snooze/dismiss/timeout
//   clk, rst (async active-low), clk1sec (1 Hz square wave), bus (alarm_trigger_if.slave)
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = DEF_RING_SEC,
    parameter int SNOOZE_SEC = DEF_SNOOZE_SEC,
    parameter int MAX_SNOOZE = DEF_MAX_SNOOZE
) (
    input  logic clk,
    input  logic rst,
    input  logic clk1sec,
    alarm_trigger_if.slave bus
);
    logic tick, lvl;
    logic match_r, match_d, hit, clear, sw_snz, sw_any;
    logic [1:0] st, st_nxt, snz_left, left_nxt;
    logic [8:0] sec_cnt, sec_nxt, sec_inc;
    logic buzz_q, ring_q, snz_q;

    sec_tick u_tick (.clk(clk), .rst(rst), .clk1sec(clk1sec), .tick(tick), .lvl(lvl));

    assign clear   = bus.bin_alarm == NO_ALARM;
    assign hit     = match_r & ~match_d;
    assign sw_snz  = bus.sw_in == SW_SNOOZE;
    assign sw_any  = |bus.sw_in;
    assign sec_inc = sec_cnt + 9'(sec_cnt != 9'h1ff);

    always_comb begin
        st_nxt   = st;
        sec_nxt  = sec_cnt;
        left_nxt = snz_left;
        if (clear) st_nxt = ST_IDLE;
        else case (st)
            ST_IDLE:  st_nxt = ST_ARMED;
            ST_ARMED: if (hit) begin
                st_nxt   = ST_RING;
                sec_nxt  = '0;
                left_nxt = 2'(MAX_SNOOZE);
            end
            ST_RING: if (sw_snz && snz_left != 2'd0) begin
                st_nxt   = ST_SNOOZE;
                sec_nxt  = '0;
                left_nxt = snz_left - 2'd1;
            end else if (sw_any) st_nxt = ST_ARMED;
            else if (tick) begin
                if (sec_cnt == 9'(RING_SEC - 1)) st_nxt = ST_ARMED;
                else sec_nxt = sec_inc;
            end
            default: if (sw_any && !sw_snz) st_nxt = ST_ARMED;
            else if (tick) begin
                if (sec_cnt == 9'(SNOOZE_SEC - 1)) begin
                    st_nxt  = ST_RING;
                    sec_nxt = '0;
                end else sec_nxt = sec_inc;
            end
        endcase
    end

    // Match history resets to "already matching" so a match present at
    // reset release is not mistaken for a new rising edge.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st       <= ST_IDLE;
            sec_cnt  <= '0;
            snz_left <= 2'(MAX_SNOOZE);
            match_r  <= 1'b1;
            match_d  <= 1'b1;
            buzz_q   <= 1'b0;
            ring_q   <= 1'b0;
            snz_q    <= 1'b0;
        end else begin
            st       <= st_nxt;
            sec_cnt  <= sec_nxt;
            snz_left <= left_nxt;
            match_r  <= !clear && bus.bin_now == bus.bin_alarm;
            match_d  <= match_r;
            buzz_q   <= st_nxt == ST_RING && lvl;
            ring_q   <= st == ST_RING;
            snz_q    <= st == ST_SNOOZE;
        end

    assign bus.buzz        = buzz_q;
    assign bus.ringing     = ring_q;
    assign bus.snoozing    = snz_q;
    assign bus.snooze_left = snz_left;
endmodule
